// File: rtl/unsigned_seq_divider_16by8_pkg.sv
// Shared definitions for the sequential unsigned restoring divider:
// default width, FSM state encoding and counter sizing.
package unsigned_seq_divider_16by8_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/unsigned_seq_divider_16by8_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit and conditionally subtract the divisor.
module unsigned_seq_divider_16by8_div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   r,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         q_bit
);

    logic [W:0] t_s;
    logic [W:0] diff_s;

    assign t_s    = {r[W-1:0], dividend_bit};
    assign diff_s = t_s - {1'b0, divisor};

    // Restore (keep t) when the trial subtraction would go negative.
    always_comb begin
        r_next = t_s;
        q_bit  = 1'b0;
        if (t_s >= {1'b0, divisor}) begin
            r_next = diff_s;
            q_bit  = 1'b1;
        end else begin
            r_next = t_s;
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Sequential unsigned restoring divider, 2W-bit dividend by W-bit divisor,
// one quotient bit per clock with valid/ready handshakes on both sides.
module unsigned_seq_divider_16by8
    import unsigned_seq_divider_16by8_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int             CW       = cnt_width(W);
    localparam logic [CW-1:0]  LAST_CNT = CW'(2 * W - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e          state_r;
    logic [2*W-1:0]  q_r;
    logic [W-1:0]    d_r;
    logic [W:0]      r_r;
    logic [CW-1:0]   cnt_r;

    logic [W:0]      r_next_s;
    logic            q_bit_s;

    unsigned_seq_divider_16by8_div_step #(.W(W)) u_div_step (
        .r            (r_r),
        .dividend_bit (q_r[2*W-1]),
        .divisor      (d_r),
        .r_next       (r_next_s),
        .q_bit        (q_bit_s)
    );

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            q_r         <= {(2*W){1'b0}};
            d_r         <= {W{1'b0}};
            r_r         <= {(W+1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= {(2*W){1'b0}};
            remainder   <= {W{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        q_r      <= dividend;
                        d_r      <= divisor;
                        r_r      <= {(W+1){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        in_ready <= 1'b0;
                        if (divisor == {W{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r     <= ST_BUSY;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    r_r   <= r_next_s;
                    q_r   <= {q_r[2*W-2:0], q_bit_s};
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_r   <= ST_DONE;
                        out_valid <= 1'b1;
                        quotient  <= {q_r[2*W-2:0], q_bit_s};
                        remainder <= r_next_s[W-1:0];
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Zero-divisor results land one edge after acceptance;
                    // q_r still holds the untouched dividend here.
                    if (!out_valid) begin
                        out_valid   <= 1'b1;
                        quotient    <= {(2*W){1'b1}};
                        remainder   <= q_r[W-1:0];
                        div_by_zero <= 1'b1;
                    end else if (out_ready) begin
                        state_r   <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Directed-vector and randomised checks for the 16-by-8 sequential divider.
module tb_unsigned_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unsigned_seq_divider_16by8 #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, then count edges until out_valid.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Hold out_ready low for 'delay' cycles checking stability, then handshake.
    task automatic consume(input int delay);
        logic [15:0] q0;
        logic [7:0]  r0;
        logic        dz0;
        q0  = quotient;
        r0  = remainder;
        dz0 = div_by_zero;
        out_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_quotient", 32'(quotient), 32'(q0));
            check("hold_remainder", 32'(remainder), 32'(r0));
            check("hold_dbz", 32'(div_by_zero), 32'(dz0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          lat;
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  x;

        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16};
        vecs[1] = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0, 16};
        vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16};
        vecs[3] = '{16'd5,     8'd200, 16'd0,     8'd5,   1'b0, 16};
        vecs[4] = '{16'd1234,  8'd0,   16'd65535, 8'd210, 1'b1, 1};
        vecs[5] = '{16'd0,     8'd0,   16'd65535, 8'd0,   1'b1, 1};
        vecs[6] = '{16'd256,   8'd16,  16'd16,    8'd0,   1'b0, 16};
        vecs[7] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16};
        vecs[8] = '{16'd40000, 8'd9,   16'd4444,  8'd4,   1'b0, 16};
        vecs[9] = '{16'd65534, 8'd255, 16'd256,   8'd254, 1'b0, 16};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = 16'd0; divisor = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dz));
            consume(0);
        end

        // Backpressure: DONE held for 10 cycles.
        run_op(16'd1000, 8'd7, lat);
        consume(10);

        // Reset partway through BUSY discards the operation.
        dividend = 16'd50000; divisor = 8'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        run_op(16'd300, 8'd3, lat);
        check("after_rst_latency", 32'(lat), 32'd16);
        check("after_rst_quotient", 32'(quotient), 32'd100);
        check("after_rst_remainder", 32'(remainder), 32'd0);
        consume(0);

        // in_valid together with rst must not be accepted.
        rst = 1'b1; in_valid = 1'b1; dividend = 16'd100; divisor = 8'd0;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_valid_in_ready", 32'(in_ready), 32'd1);
        check("rst_valid_out_valid", 32'(out_valid), 32'd0);

        // Random operands with random backpressure.
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, lat);
            check("rnd_quotient", 32'(quotient), 32'(a / b));
            check("rnd_remainder", 32'(remainder), 32'(a % b));
            check("rnd_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("rnd_rem_lt_div", 32'(remainder < b), 32'd1);
            consume(int'($urandom_range(0, 3)));
        end

        // Operand recovery from exact 8x8 products.
        for (int i = 0; i < 100; i++) begin
            x = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            a = 16'(x) * 16'(b);
            run_op(a, b, lat);
            check("recover_x", 32'(quotient), 32'(x));
            check("recover_rem", 32'(remainder), 32'd0);
            consume(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
